// File: rtl/dsp_bus_arbiter_pkg.sv
// Shared constants for the DSP bus arbiter: FSM encodings and a sim-only state decode.
// DSP_ARB_LOCK_EN is left undefined by default (lock feature off).
package dsp_bus_arbiter_pkg;

  localparam logic [1:0] DSP_ARB_STATE_IDLE  = 2'd0;
  localparam logic [1:0] DSP_ARB_STATE_ISSUE = 2'd1;
  localparam logic [1:0] DSP_ARB_STATE_BUSY  = 2'd2;

  localparam int DSP_ARB_MAX_REQ = 4;

`ifndef SYNTHESIS
  function automatic string state_name(input logic [1:0] s);
    case (s)
      DSP_ARB_STATE_IDLE:  return "IDLE";
      DSP_ARB_STATE_ISSUE: return "ISSUE";
      DSP_ARB_STATE_BUSY:  return "BUSY";
      default:             return "ILLEGAL";
    endcase
  endfunction
`endif

endpackage

// File: rtl/dsp_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant, in circular order.
// Reusable by other schedulers; callers with fewer than four requesters tie the spare inputs low.
module dsp_rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant_idx,
  output logic       any_valid
);

  logic [1:0] idx;

  // Offset 4 wraps back to last_grant itself, so the previous owner is checked last.
  always_comb begin
    grant_idx = last_grant;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!any_valid && req[idx]) begin
        grant_idx = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master command port among up to four DSP sequencers.
// Define DSP_ARB_LOCK_EN to let a requester hold its grant across transactions via req_lock.
module dsp_bus_arbiter
  import dsp_bus_arbiter_pkg::*;
#(
  parameter int dw   = 32,
  parameter int aw   = 32,
  parameter int NREQ = 4
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [NREQ-1:0]   req_start,
  input  logic [NREQ*aw-1:0] req_address,
  input  logic [NREQ*4-1:0] req_selection,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*dw-1:0] req_data_wr,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_active,
  output logic [dw-1:0]     req_data_rd,
  output logic              start,
  output logic [aw-1:0]     address,
  output logic [3:0]        selection,
  output logic              write,
  output logic [dw-1:0]     data_wr,
  input  logic              active,
  input  logic [dw-1:0]     data_rd,
  output logic [1:0]        grant,
  output logic              grant_valid
);

  logic [1:0]    state;
  logic [1:0]    last_grant;
  logic [3:0]    req_vec;
  logic [3:0]    elig_vec;
  logic [3:0]    act_vec;
  logic [1:0]    pick;
  logic          any_req;
  logic          lock_hold;
  logic          lock_exit;
  logic [aw-1:0] pick_address;
  logic [3:0]    pick_selection;
  logic          pick_write;
  logic [dw-1:0] pick_data_wr;

  always_comb begin
    req_vec = '0;
    req_vec[NREQ-1:0] = req_start;
  end

`ifdef DSP_ARB_LOCK_EN
  logic [3:0] lock_vec;

  always_comb begin
    lock_vec = '0;
    lock_vec[NREQ-1:0] = req_lock;
  end

  // A held lock only counts in IDLE; dropping req_lock there reopens arbitration the same cycle.
  assign lock_hold = (state == DSP_ARB_STATE_IDLE) && grant_valid && lock_vec[grant];
  assign lock_exit = lock_vec[grant];
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
  assign lock_exit   = 1'b0;
`endif

  assign elig_vec = lock_hold ? (req_vec & (4'b0001 << grant)) : req_vec;

  dsp_rr_picker u_picker (
    .req        (elig_vec),
    .last_grant (last_grant),
    .grant_idx  (pick),
    .any_valid  (any_req)
  );

  always_comb begin
    pick_address   = '0;
    pick_selection = '0;
    pick_write     = 1'b0;
    pick_data_wr   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 2'(i)) begin
        pick_address   = req_address[i*aw +: aw];
        pick_selection = req_selection[i*4 +: 4];
        pick_write     = req_write[i];
        pick_data_wr   = req_data_wr[i*dw +: dw];
      end
    end
  end

  always_comb begin
    act_vec = '0;
    if (state == DSP_ARB_STATE_BUSY) act_vec[grant] = active;
  end

  assign req_active  = act_vec[NREQ-1:0];
  assign req_data_rd = data_rd;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state       <= DSP_ARB_STATE_IDLE;
      start       <= 1'b0;
      address     <= '0;
      selection   <= '0;
      write       <= 1'b0;
      data_wr     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      last_grant  <= '0;
    end else begin
      case (state)
        DSP_ARB_STATE_IDLE: begin
          if (any_req) begin
            grant       <= pick;
            grant_valid <= 1'b1;
            address     <= pick_address;
            selection   <= pick_selection;
            write       <= pick_write;
            data_wr     <= pick_data_wr;
            start       <= 1'b1;
            state       <= DSP_ARB_STATE_ISSUE;
          end else if (!lock_hold) begin
            grant_valid <= 1'b0;
          end
        end
        DSP_ARB_STATE_ISSUE: begin
          if (active) begin
            start <= 1'b0;
            state <= DSP_ARB_STATE_BUSY;
          end
        end
        DSP_ARB_STATE_BUSY: begin
          if (!active) begin
            last_grant  <= grant;
            grant_valid <= lock_exit;
            state       <= DSP_ARB_STATE_IDLE;
          end
        end
        default: begin
          start <= 1'b0;
          state <= DSP_ARB_STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_bus_arbiter.sv
// Self-checking bench for dsp_bus_arbiter: a master model pops expected grants/fields from a scoreboard.
module tb_dsp_bus_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NREQ = 4;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [NREQ-1:0]   req_start;
  logic [NREQ*AW-1:0] req_address;
  logic [NREQ*4-1:0] req_selection;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*DW-1:0] req_data_wr;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_active;
  logic [DW-1:0]     req_data_rd;
  logic              start;
  logic [AW-1:0]     address;
  logic [3:0]        selection;
  logic              write;
  logic [DW-1:0]     data_wr;
  logic              active;
  logic [DW-1:0]     data_rd;
  logic [1:0]        grant;
  logic              grant_valid;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
  } sb_entry_t;

  sb_entry_t     exp_q[$];
  logic [31:0]   rd_q[$];
  int            checks = 0;
  int            failures = 0;
  int            rem[NREQ];
  int            hold_extra = 0;
  bit            gap_chk = 0;
  bit            perturb = 0;
  longint        cyc = 0;
  longint        last_acc = -1;
  logic [NREQ-1:0] prev_act = '0;

  dsp_bus_arbiter #(.dw(DW), .aw(AW), .NREQ(NREQ)) dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .req_start     (req_start),
    .req_address   (req_address),
    .req_selection (req_selection),
    .req_write     (req_write),
    .req_data_wr   (req_data_wr),
    .req_lock      (req_lock),
    .req_active    (req_active),
    .req_data_rd   (req_data_rd),
    .start         (start),
    .address       (address),
    .selection     (selection),
    .write         (write),
    .data_wr       (data_wr),
    .active        (active),
    .data_rd       (data_rd),
    .grant         (grant),
    .grant_valid   (grant_valid)
  );

  always #5 wb_clk = ~wb_clk;
  always @(posedge wb_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] s,
                         input logic w, input logic [31:0] d);
    req_address[i*AW +: AW]  = a;
    req_selection[i*4 +: 4]  = s;
    req_write[i]             = w;
    req_data_wr[i*DW +: DW]  = d;
  endtask

  task automatic push_exp(input int i, input logic [31:0] rd);
    sb_entry_t e;
    e.g    = 2'(i);
    e.addr = req_address[i*AW +: AW];
    e.sel  = req_selection[i*4 +: 4];
    e.we   = req_write[i];
    e.wd   = req_data_wr[i*DW +: DW];
    e.rd   = rd;
    exp_q.push_back(e);
  endtask

  function automatic bit rem_all_zero();
    for (int i = 0; i < NREQ; i++) if (rem[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge wb_clk);
      n++;
      done = (exp_q.size() == 0) && (rd_q.size() == 0) && !start && !grant_valid &&
             !active && rem_all_zero();
    end
    check_val({tag, "_complete"}, 64'(done), 64'd1);
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    while (!start && n < budget) begin
      @(negedge wb_clk);
      n++;
    end
    check_val({tag, "_start_seen"}, 64'(start), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst        = 1'b1;
    req_start     = '0;
    req_lock      = '0;
    req_write     = '0;
    req_address   = '0;
    req_selection = '0;
    req_data_wr   = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  // Wishbone master model: accepts on start, holds active for two or more cycles.
  initial begin : master_model
    sb_entry_t e;
    active  = 1'b0;
    data_rd = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      if (start && !wb_rst && !active) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_start", 64'(start), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("grant", 64'(grant), 64'(e.g));
          check_val("grant_valid", 64'(grant_valid), 64'd1);
          check_val("address", 64'(address), 64'(e.addr));
          check_val("selection", 64'(selection), 64'(e.sel));
          check_val("write", 64'(write), 64'(e.we));
          check_val("data_wr", 64'(data_wr), 64'(e.wd));
          check_val("issue_req_active", 64'(req_active), 64'd0);
          if (gap_chk && last_acc >= 0) check_val("issue_gap", 64'(cyc - last_acc), 64'd4);
          last_acc = cyc;
          active  = 1'b1;
          data_rd = e.rd;
          rd_q.push_back(e.rd);
          @(posedge wb_clk);
          #1;
          check_val("busy_req_active", 64'(req_active), 64'd1 << e.g);
          check_val("busy_start", 64'(start), 64'd0);
          @(posedge wb_clk);
          #1;
          check_val("busy_address_hold", 64'(address), 64'(e.addr));
          check_val("busy_data_wr_hold", 64'(data_wr), 64'(e.wd));
          for (int k = 0; k < hold_extra; k++) begin
            @(posedge wb_clk);
            #1;
          end
          active = 1'b0;
        end
      end
    end
  end

  // Requester model: drop start once active is seen, check read data when active falls.
  initial begin : requester_model
    logic [31:0] exp_rd;
    forever begin
      @(posedge wb_clk);
      #2;
      for (int j = 0; j < NREQ; j++) begin
        if (req_active[j] && !prev_act[j]) begin
          if (rem[j] > 0) rem[j]--;
          if (rem[j] == 0) begin
            req_start[j] = 1'b0;
            req_lock[j]  = 1'b0;
          end
          if (perturb) begin
            req_address[3*AW +: AW] = 32'hBAD0_0003;
            req_address[2*AW +: AW] = 32'hBAD0_0002;
            req_data_wr[2*DW +: DW] = 32'hFFFF_0000;
          end
        end
        if (!req_active[j] && prev_act[j]) begin
          if (rd_q.size() == 0) begin
            check_val("rd_unexpected", 64'(req_data_rd), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_rd = rd_q.pop_front();
            check_val("req_data_rd", 64'(req_data_rd), 64'(exp_rd));
          end
        end
        prev_act[j] = req_active[j];
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    wb_rst        = 1'b1;
    req_start     = '0;
    req_lock      = '0;
    req_write     = '0;
    req_address   = '0;
    req_selection = '0;
    req_data_wr   = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    repeat (3) @(negedge wb_clk);
    check_val("rst_start", 64'(start), 64'd0);
    check_val("rst_grant", 64'(grant), 64'd0);
    check_val("rst_grant_valid", 64'(grant_valid), 64'd0);
    check_val("rst_address", 64'(address), 64'd0);
    check_val("rst_selection", 64'(selection), 64'd0);
    check_val("rst_write", 64'(write), 64'd0);
    check_val("rst_data_wr", 64'(data_wr), 64'd0);
    check_val("rst_req_active", 64'(req_active), 64'd0);
    wb_rst = 1'b0;

    // single read by requester 1
    set_req(1, 32'h2000_0010, 4'hF, 1'b0, 32'h0);
    push_exp(1, 32'hDEAD_BEEF);
    rem[1] = 1;
    @(negedge wb_clk);
    req_start[1] = 1'b1;
    check_val("t1_start_before", 64'(start), 64'd0);
    @(posedge wb_clk);
    #1;
    check_val("t1_start_next", 64'(start), 64'd1);
    check_val("t1_grant", 64'(grant), 64'd1);
    wait_idle("t1", 40);

    // all four continuously requesting, two transactions each
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000_0000 + 32'(i * 16), 4'(i + 1), i[0], 32'hC0DE_0000 + 32'(i));
    push_exp(1, 32'hA000_0001);
    push_exp(2, 32'hA000_0002);
    push_exp(3, 32'hA000_0003);
    push_exp(0, 32'hA000_0004);
    push_exp(1, 32'hA000_0005);
    push_exp(2, 32'hA000_0006);
    push_exp(3, 32'hA000_0007);
    push_exp(0, 32'hA000_0008);
    for (int i = 0; i < NREQ; i++) rem[i] = 2;
    gap_chk  = 1'b1;
    last_acc = -1;
    @(negedge wb_clk);
    req_start = '1;
    wait_idle("t2", 150);
    gap_chk = 1'b0;

    // requester 2 write while requester 3 (and 2 itself) change fields mid-transaction
    do_reset();
    set_req(2, 32'h3000_0020, 4'hF, 1'b1, 32'h1234_5678);
    set_req(3, 32'h4000_0030, 4'h3, 1'b0, 32'h0);
    push_exp(2, 32'hB000_0002);
    rem[2]  = 1;
    perturb = 1'b1;
    @(negedge wb_clk);
    req_start[2] = 1'b1;
    wait_idle("t3", 40);
    perturb = 1'b0;

    // reset asserted while BUSY, then re-grant
    do_reset();
    hold_extra = 4;
    set_req(0, 32'h6000_0000, 4'hF, 1'b0, 32'h0);
    push_exp(0, 32'h6666_0001);
    rem[0] = 1;
    @(negedge wb_clk);
    req_start[0] = 1'b1;
    begin
      int n;
      n = 0;
      while (!req_active[0] && n < 20) begin
        @(negedge wb_clk);
        n++;
      end
      check_val("t4_busy_seen", 64'(req_active[0]), 64'd1);
    end
    @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    check_val("t4_rst_start", 64'(start), 64'd0);
    check_val("t4_rst_grant_valid", 64'(grant_valid), 64'd0);
    check_val("t4_rst_req_active", 64'(req_active), 64'd0);
    check_val("t4_rst_grant", 64'(grant), 64'd0);
    repeat (5) @(negedge wb_clk);
    wb_rst     = 1'b0;
    hold_extra = 0;
    push_exp(0, 32'h6666_0002);
    rem[0] = 1;
    req_start[0] = 1'b1;
    wait_idle("t4", 40);

    // requester 0 holds req_lock while requester 1 competes
    do_reset();
    set_req(0, 32'h5000_0000, 4'hF, 1'b0, 32'h0);
    set_req(1, 32'h5100_0000, 4'hC, 1'b1, 32'hCAFE_0001);
    req_lock[0] = 1'b1;
`ifdef DSP_ARB_LOCK_EN
    push_exp(0, 32'hD000_0001);
    push_exp(0, 32'hD000_0002);
    push_exp(0, 32'hD000_0003);
    push_exp(1, 32'hD000_0004);
    rem[0] = 3;
    rem[1] = 1;
`else
    push_exp(0, 32'hD000_0001);
    push_exp(1, 32'hD000_0002);
    push_exp(0, 32'hD000_0003);
    push_exp(1, 32'hD000_0004);
    rem[0] = 2;
    rem[1] = 2;
`endif
    @(negedge wb_clk);
    req_start[0] = 1'b1;
    wait_start("t5", 20);
    req_start[1] = 1'b1;
    wait_idle("t5", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
